// File: rtl/iter_comparator.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per cycle, MSB chunk first,
// and registers equal/greater/less flags behind a start/busy/done handshake.
module iter_comparator #(
  parameter int WIDTH      = 18,
  parameter int CHUNK      = 6,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flag_clr,
  output logic             busy,
  output logic             done,
  output logic             ZF_register,
  output logic             CF_register,
  output logic             LT_register
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   op1_r;
  logic [WIDTH-1:0]   op2_r;
  logic               mode_r;
  logic               found_r;
  logic               found_gt_r;
  logic               busy_r;
  logic               done_r;
  logic               zf_r;
  logic               cf_r;
  logic               lt_r;

  logic [WIDTH-1:0]   shift_a_s;
  logic [WIDTH-1:0]   shift_b_s;
  logic [CHUNK-1:0]   chunk_a_s;
  logic [CHUNK-1:0]   chunk_b_s;
  logic               flip_s;
  logic               ne_s;
  logic               gt_s;
  logic               last_s;
  logic               accept_s;
  logic               finish_s;
  logic               res_eq_s;
  logic               res_gt_s;

  // Chunk selection and per-chunk compare of the latched operands
  always_comb begin
    shift_a_s = op1_r >> (int'(idx_r) * CHUNK);
    shift_b_s = op2_r >> (int'(idx_r) * CHUNK);
    // Flipping the sign bit of the top chunk turns a signed compare into an unsigned one
    flip_s    = mode_r && (idx_r == IDX_TOP);
    chunk_a_s = shift_a_s[CHUNK-1:0] ^ {flip_s, {(CHUNK-1){1'b0}}};
    chunk_b_s = shift_b_s[CHUNK-1:0] ^ {flip_s, {(CHUNK-1){1'b0}}};
    ne_s      = (chunk_a_s != chunk_b_s);
    gt_s      = (chunk_a_s > chunk_b_s);
    last_s    = (idx_r == {IDX_W{1'b0}});
    accept_s  = start && ((state_r == IDLE) || (state_r == DONE));
    finish_s  = (state_r == BUSY) && (last_s || ((EARLY_EXIT != 0) && ne_s));
    res_eq_s  = !found_r && !ne_s;
    res_gt_s  = found_r ? found_gt_r : gt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (finish_s) state_nxt_s = DONE;
        else          state_nxt_s = BUSY;
      end
      DONE: begin
        if (accept_s) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == BUSY);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand latch, chunk index and first-difference tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1_r      <= {WIDTH{1'b0}};
      op2_r      <= {WIDTH{1'b0}};
      mode_r     <= 1'b0;
      idx_r      <= IDX_TOP;
      found_r    <= 1'b0;
      found_gt_r <= 1'b0;
    end else if (accept_s) begin
      op1_r      <= operand1;
      op2_r      <= operand2;
      mode_r     <= signed_mode;
      idx_r      <= IDX_TOP;
      found_r    <= 1'b0;
      found_gt_r <= 1'b0;
    end else if ((state_r == BUSY) && !finish_s) begin
      idx_r <= idx_r - IDX_W'(1);
      // Only the most significant differing chunk decides the result
      if (ne_s && !found_r) begin
        found_r    <= 1'b1;
        found_gt_r <= gt_s;
      end
    end
  end

  // Condition flags: a completing compare takes priority over flag_clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zf_r <= 1'b0;
      cf_r <= 1'b0;
      lt_r <= 1'b0;
    end else if (finish_s) begin
      zf_r <= res_eq_s;
      cf_r <= !res_eq_s && res_gt_s;
      lt_r <= !res_eq_s && !res_gt_s;
    end else if (flag_clr) begin
      zf_r <= 1'b0;
      cf_r <= 1'b0;
      lt_r <= 1'b0;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign ZF_register = zf_r;
  assign CF_register = cf_r;
  assign LT_register = lt_r;

endmodule

// File: tb/tb_iter_comparator.sv
// Self-checking bench for iter_comparator: one instance with early exit, one without,
// checked against an arithmetic reference model.
module tb_iter_comparator;

  localparam int W  = 18;
  localparam int C  = 6;
  localparam int NC = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic         flag_clr = 1'b0;
  logic         busy_a, done_a, zf_a, cf_a, lt_a;
  logic         busy_b, done_b, zf_b, cf_b, lt_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  iter_comparator #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .signed_mode(signed_mode),
    .operand1(operand1), .operand2(operand2), .flag_clr(flag_clr),
    .busy(busy_a), .done(done_a),
    .ZF_register(zf_a), .CF_register(cf_a), .LT_register(lt_a)
  );

  iter_comparator #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .signed_mode(signed_mode),
    .operand1(operand1), .operand2(operand2), .flag_clr(flag_clr),
    .busy(busy_b), .done(done_b),
    .ZF_register(zf_b), .CF_register(cf_b), .LT_register(lt_b)
  );

  // Reference: result by plain arithmetic, latency by locating the top differing chunk
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                       input bit ee, output int k, output bit zf, output bit cf,
                       output bit lt);
    logic [W-1:0] diff;
    bit           gt;
    bit           hit;
    diff = a ^ b;
    gt   = sm ? ($signed(a) > $signed(b)) : (a > b);
    zf   = (a == b);
    cf   = !zf && gt;
    lt   = !zf && !gt;
    k    = NC;
    hit  = 1'b0;
    if (ee) begin
      for (int c = NC - 1; c >= 0; c--) begin
        if (!hit && (((diff >> (c * C)) & ((1 << C) - 1)) != 0)) begin
          k   = NC - c;
          hit = 1'b1;
        end
      end
    end
  endtask

  task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                             input bit ee, input string nm);
    int k, cyc;
    bit ezf, ecf, elt;
    model(a, b, sm, ee, k, ezf, ecf, elt);
    @(negedge clk);
    operand1 = a; operand2 = b; signed_mode = sm;
    if (ee) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    // Scramble inputs: the compare must use the latched values
    operand1 = W'($urandom); operand2 = W'($urandom); signed_mode = ~sm;
    n_total++;
    if ((ee ? busy_a : busy_b) !== 1'b1)
      $display("FAIL %s busy: got %b want 1", nm, ee ? busy_a : busy_b);
    else n_pass++;
    cyc = 0;
    while ((ee ? done_a : done_b) !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_total++;
    if (cyc != k) $display("FAIL %s latency: got %0d want %0d", nm, cyc, k);
    else n_pass++;
    n_total++;
    if ((ee ? {zf_a, cf_a, lt_a} : {zf_b, cf_b, lt_b}) !== {ezf, ecf, elt})
      $display("FAIL %s flags ZF/CF/LT: got %b want %b", nm,
               ee ? {zf_a, cf_a, lt_a} : {zf_b, cf_b, lt_b}, {ezf, ecf, elt});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ((ee ? {done_a, busy_a} : {done_b, busy_b}) !== 2'b00)
      $display("FAIL %s done_pulse: got done/busy %b want 00", nm,
               ee ? {done_a, busy_a} : {done_b, busy_b});
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({busy_a, done_a, zf_a, cf_a, lt_a, busy_b, done_b, zf_b, cf_b, lt_b} !== 10'b0)
      $display("FAIL reset_outputs: got %b want 0000000000",
               {busy_a, done_a, zf_a, cf_a, lt_a, busy_b, done_b, zf_b, cf_b, lt_b});
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({busy_a, done_a, busy_b, done_b} !== 4'b0)
      $display("FAIL reset_release: got %b want 0000", {busy_a, done_a, busy_b, done_b});
    else n_pass++;
  endtask

  task automatic test_directed;
    run_compare(18'h2AAAA, 18'h2AAAA, 1'b0, 1'b1, "equal_unsigned");
    run_compare(18'h3F000, 18'h01000, 1'b0, 1'b1, "early_exit_gt");
    run_compare(18'h3F000, 18'h01000, 1'b0, 1'b0, "no_early_exit_gt");
    run_compare(18'h20000, 18'h00001, 1'b1, 1'b1, "signed_neg_lt");
    run_compare(18'h20000, 18'h00001, 1'b0, 1'b1, "unsigned_big_gt");
    run_compare(18'h3FFFF, 18'h3FFFE, 1'b1, 1'b1, "signed_low_chunk");
    run_compare(18'h2AAAA, 18'h2AAAA, 1'b1, 1'b0, "equal_no_early");
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, r;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      r = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = {a[W-1:W-C], r[W-C-1:0]};
        2:       b = {a[W-1:C], r[C-1:0]};
        default: b = r;
      endcase
      run_compare(a, b, 1'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    @(negedge clk);
    operand1 = 18'h15555; operand2 = 18'h15555; signed_mode = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    operand1 = 18'h3F000; operand2 = 18'h01000; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_total++;
    if (cyc != 3) $display("FAIL busy_start latency: got %0d want 3", cyc);
    else n_pass++;
    n_total++;
    if ({zf_a, cf_a, lt_a} !== 3'b100)
      $display("FAIL busy_start flags: got %b want 100", {zf_a, cf_a, lt_a});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (busy_a !== 1'b0) $display("FAIL busy_start no_queue: got busy %b want 0", busy_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    operand1 = 18'h3F000; operand2 = 18'h01000; signed_mode = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if ({done_a, zf_a, cf_a, lt_a} !== 4'b1010)
      $display("FAIL b2b first: got done/ZF/CF/LT %b want 1010", {done_a, zf_a, cf_a, lt_a});
    else n_pass++;
    operand1 = 18'h2AAAA; operand2 = 18'h2AAAA;
    @(posedge clk); #1;
    start_a = 1'b0;
    n_total++;
    if ({busy_a, done_a} !== 2'b10)
      $display("FAIL b2b restart: got busy/done %b want 10", {busy_a, done_a});
    else n_pass++;
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_total++;
    if (cyc != 3 || {zf_a, cf_a, lt_a} !== 3'b100)
      $display("FAIL b2b second: got latency %0d flags %b want 3 100", cyc, {zf_a, cf_a, lt_a});
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    operand1 = 18'h00005; operand2 = 18'h00004; signed_mode = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    n_total++;
    if ({busy_a, done_a, zf_a, cf_a, lt_a, zf_b, cf_b, lt_b} !== 8'b0)
      $display("FAIL reset_mid outputs: got %b want 00000000",
               {busy_a, done_a, zf_a, cf_a, lt_a, zf_b, cf_b, lt_b});
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_a === 1'b1 || busy_a === 1'b1) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL reset_mid no_done: got %0d active cycles want 0", seen);
    else n_pass++;
    run_compare(18'h00005, 18'h00004, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_flag_clr;
    @(negedge clk);
    operand1 = 18'h01234; operand2 = 18'h01234; signed_mode = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    n_total++;
    if ({done_a, zf_a, cf_a, lt_a} !== 4'b1100)
      $display("FAIL clr_coincident: got done/ZF/CF/LT %b want 1100", {done_a, zf_a, cf_a, lt_a});
    else n_pass++;
    @(negedge clk); flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    n_total++;
    if ({zf_a, cf_a, lt_a, busy_a, done_a} !== 5'b0)
      $display("FAIL clr_later: got ZF/CF/LT/busy/done %b want 00000",
               {zf_a, cf_a, lt_a, busy_a, done_a});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({zf_a, cf_a, lt_a, busy_a} !== 4'b0)
      $display("FAIL clr_hold: got ZF/CF/LT/busy %b want 0000", {zf_a, cf_a, lt_a, busy_a});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_flag_clr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
